// File: rtl/channel_arb_pkg.sv
// Shared helpers for the channel round-robin arbiter: tag width function and default source-id type.
package channel_arb_pkg;

  function automatic int clog2_min1(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int DEF_M = 4;
  typedef logic [clog2_min1(DEF_M)-1:0] src_id_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping modulo M.
module rr_priority_pick
  import channel_arb_pkg::*;
#(
  parameter  int M   = 4,
  localparam int IdW = clog2_min1(M)
) (
  input  logic [M-1:0]   req,
  input  logic [IdW-1:0] ptr,
  output logic [IdW-1:0] gnt_idx,
  output logic           any
);

  logic [2*M-1:0] dbl;
  logic [M-1:0]   rot;

  // Doubling the vector makes the rotate a plain shift; the lowest set bit of rot wins.
  always_comb begin
    dbl     = {req, req};
    rot     = M'(dbl >> ptr);
    any     = |req;
    gnt_idx = '0;
    for (int k = M-1; k >= 0; k--)
      if (rot[k]) gnt_idx = IdW'((int'(ptr) + k) % M);
  end

endmodule

// File: rtl/channel_rr_arbiter.sv
// M-to-1 round-robin channel merge with source tagging, one-entry output register and optional packet lock.
module channel_rr_arbiter
  import channel_arb_pkg::*;
#(
  parameter  int N          = 8,
  parameter  int M          = 4,
  parameter  int PacketMode = 0,
  parameter  int TailBit    = N-1,
  localparam int IdW        = clog2_min1(M)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [M-1:0]          in_v,
  input  logic [M-1:0][N-1:0]   in_d,
  output logic [M-1:0]          in_a,
  output logic                  out_v,
  output logic [IdW+N-1:0]      out_d,
  input  logic                  out_a,
  output logic                  locked,
  output logic [IdW-1:0]        owner
);

  logic [IdW-1:0] ptr, g, g_next;
  logic [M-1:0]   req;
  logic           any, load, xfer, tail;

  // While locked only the owner may be granted; its valid alone decides a transfer.
  always_comb begin
    req = in_v;
    if (locked) begin
      req        = '0;
      req[owner] = in_v[owner];
    end
  end

  rr_priority_pick #(.M(M)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt_idx (g),
    .any     (any)
  );

  assign load   = ~out_v | out_a;
  assign xfer   = load & any;
  assign g_next = (int'(g) == M-1) ? '0 : g + 1'b1;
  assign tail   = in_d[g][TailBit];

  always_comb begin
    in_a = '0;
    if (xfer) in_a[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_v  <= 1'b0;
      out_d  <= '0;
      locked <= 1'b0;
      owner  <= '0;
      ptr    <= '0;
    end else if (xfer) begin
      out_v <= 1'b1;
      out_d <= {g, in_d[g]};
      if (PacketMode == 0) begin
        ptr <= g_next;
      end else if (tail) begin
        locked <= 1'b0;
        owner  <= '0;
        ptr    <= g_next;
      end else begin
        locked <= 1'b1;
        owner  <= g;
      end
    end else if (out_a) begin
      out_v <= 1'b0;
    end
  end

endmodule
